// File: rtl/rr_tdm_pkg.sv
// Shared definitions for the round-robin TDM demultiplexer.
// Contents:
//   tdm_state_e    - framing FSM states (HUNT, COLLECT)
//   DEF_DATA_WIDTH - default bits per TDM slot
//   DEF_NUM_LANES  - default slots per frame
//   ERR_CNT_WIDTH  - width of the optional framing-error counter
package rr_tdm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_LANES  = 2;
  localparam int ERR_CNT_WIDTH  = 8;

endpackage

// File: rtl/rr_tdm_demux_slot_counter.sv
// Module tdm_slot_counter: mod-NUM_LANES slot counter for the TDM demux.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (count -> 0)
//   clr   - force count to 0 (highest priority after reset)
//   load1 - force count to 1 (a slot-0 beat was just accepted)
//   en    - advance count, wrapping from NUM_LANES-1 to 0
//   count - current slot index
//   wrap  - high when this cycle's advance wraps the counter (frame complete)
module tdm_slot_counter
  import rr_tdm_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  localparam int CNT_W = $clog2(NUM_LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_LANES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Only a plain advance can wrap; clr/load1 override en.
  assign wrap = en && !clr && !load1 && (count == LAST);

endmodule

// File: rtl/rr_tdm_demux.sv
// Round-robin TDM demultiplexer: collects NUM_LANES consecutive valid beats,
// starting at a beat flagged tdm_sof, and presents the completed frame in
// parallel on lanes_out (lane 0 in the MSBs) with a one-cycle lanes_valid.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   tdm_valid   - a beat is present on tdm_data/tdm_sof
//   tdm_sof     - this beat is slot 0 of a frame
//   tdm_data    - slot payload
//   lanes_out   - last complete frame
//   lanes_valid - one-cycle pulse when lanes_out updates
//   in_sync     - framing is locked (state COLLECT)
//   frame_err   - one-cycle pulse on early or missing SOF
//   err_cnt     - saturating framing-error count, only when the macro
//                 RR_TDM_DEMUX_ERR_CNT_EN is defined
module rr_tdm_demux
  import rr_tdm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tdm_valid,
  input  logic                            tdm_sof,
  input  logic [DATA_WIDTH-1:0]           tdm_data,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lanes_out,
  output logic                            lanes_valid,
  output logic                            in_sync,
  output logic                            frame_err
`ifdef RR_TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0]        err_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_LANES);

  tdm_state_e state, state_nxt;

  logic [CNT_W-1:0]      slot_cnt;
  logic [CNT_W-1:0]      store_idx;
  logic                  cnt_clr, cnt_load1, cnt_en, frame_done;
  logic                  store, err_nxt;
  logic [DATA_WIDTH-1:0] asm_buf [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0] frame_next;

  tdm_slot_counter #(.NUM_LANES(NUM_LANES)) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .en    (cnt_en),
    .count (slot_cnt),
    .wrap  (frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Any SOF beat restarts the frame at slot 0; in COLLECT it is an error
  // only when it cuts a partial frame short.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_en    = 1'b0;
    store     = 1'b0;
    store_idx = '0;
    err_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (tdm_valid && tdm_sof) begin
          store     = 1'b1;
          cnt_load1 = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (tdm_valid) begin
          if (tdm_sof) begin
            store     = 1'b1;
            cnt_load1 = 1'b1;
            err_nxt   = (slot_cnt != '0);
          end else if (slot_cnt != '0) begin
            store     = 1'b1;
            store_idx = slot_cnt;
            cnt_en    = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = HUNT;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // The final slot goes straight from tdm_data to lanes_out so that a frame
  // completes in the cycle after its last beat without a buffer round-trip.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i == NUM_LANES - 1)
        frame_next[(NUM_LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = tdm_data;
      else
        frame_next[(NUM_LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = asm_buf[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) asm_buf[i] <= '0;
      lanes_out   <= '0;
      lanes_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (store) asm_buf[store_idx] <= tdm_data;
      if (frame_done) lanes_out <= frame_next;
      lanes_valid <= frame_done;
      frame_err   <= err_nxt;
    end
  end

  assign in_sync = (state == COLLECT);

`ifdef RR_TDM_DEMUX_ERR_CNT_EN
  // Counts alongside the frame_err pulse and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_nxt && (err_cnt != '1))
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end
`else
  // Error counter not present in this build.
`endif

endmodule
